// File: rtl/ma_feeder.sv
// Packs weight/pixel stream words into MA operand buses, pulses mStart, returns per-channel accumulates.
// mStart one cycle after the last needed word; s_ready low outside LOAD. MA_FEEDER_TIMEOUT_EN adds a WAIT watchdog.
module ma_feeder #(
    parameter int DATA_WIDTH     = 32,
    parameter int KERNEL_SIZE    = 3,
    parameter int CHANNELS       = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int N             = KERNEL_SIZE * KERNEL_SIZE,
    localparam int TOTAL         = CHANNELS * N
) (
    input  logic                        Clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        s_kind,
    input  logic [DATA_WIDTH-1:0]       s_data,
    output logic [TOTAL*DATA_WIDTH-1:0] multiplier_output,
    output logic [TOTAL*DATA_WIDTH-1:0] multiplicand_output,
    output logic [N-1:0]                mStart,
    input  logic [CHANNELS*32-1:0]      finalAccumulate,
    input  logic [CHANNELS-1:0]         finalReady,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [CHANNELS*32-1:0]      m_data,
    output logic                        busy,
    output logic                        ma_rst,
    output logic                        timeout_err
);

    localparam int CW = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_OUT} state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CW-1:0]                 r_w_cnt;
    logic [CW-1:0]                 r_pix_cnt;
    logic                          r_w_full;
    logic [CHANNELS-1:0]           r_done;
    logic [TOTAL*DATA_WIDTH-1:0]   r_mult;
    logic [TOTAL*DATA_WIDTH-1:0]   r_mcand;
    logic [CHANNELS*32-1:0]        r_m_data;
    logic                          r_timeout_err;

    logic                          w_acc_w;
    logic                          w_acc_p;
    logic                          w_w_full_nxt;
    logic                          w_pix_full_nxt;
    logic [CHANNELS-1:0]           w_done_nxt;
    logic                          w_all_done;
    logic                          w_timeout;

    assign w_acc_w = s_valid & s_ready & s_kind;
    assign w_acc_p = s_valid & s_ready & ~s_kind;

    // Fullness is judged on the post-accept counter values so START follows the last word directly.
    assign w_w_full_nxt   = r_w_full | (w_acc_w && (r_w_cnt == CW'(TOTAL - 1)));
    assign w_pix_full_nxt = (r_pix_cnt == CW'(TOTAL)) | (w_acc_p && (r_pix_cnt == CW'(TOTAL - 1)));

    assign w_done_nxt = r_done | (finalReady & {CHANNELS{r_state == S_WAIT}});
    assign w_all_done = &w_done_nxt;

`ifdef MA_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait_cnt;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !w_all_done && (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (w_w_full_nxt && w_pix_full_nxt) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_all_done) begin
                    w_state_nxt = S_OUT;
                end else if (w_timeout) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_OUT:   if (m_ready) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        mStart  = '0;
        m_valid = 1'b0;
        busy    = 1'b1;
        ma_rst  = 1'b0;
        case (r_state)
            S_LOAD: begin
                busy    = 1'b0;
                s_ready = s_kind | (r_pix_cnt < CW'(TOTAL));
            end
            S_START: mStart  = '1;
            S_WAIT:  ma_rst  = w_timeout;
            S_OUT:   m_valid = 1'b1;
            default: busy    = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_cnt       <= '0;
            r_pix_cnt     <= '0;
            r_w_full      <= 1'b0;
            r_done        <= '0;
            r_mult        <= '0;
            r_mcand       <= '0;
            r_m_data      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_acc_w) begin
                r_mcand[int'(r_w_cnt)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                r_w_cnt <= (r_w_cnt == CW'(TOTAL - 1)) ? '0 : r_w_cnt + 1'b1;
            end
            r_w_full <= w_w_full_nxt;

            if (w_acc_p) begin
                r_mult[int'(r_pix_cnt)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end else if (r_state == S_START) begin
                r_pix_cnt <= '0;
            end

            r_done <= (r_state == S_START) ? '0 : w_done_nxt;

            // Only the first report per channel is kept; a level-style finalReady cannot overwrite it.
            for (int c = 0; c < CHANNELS; c++) begin
                if ((r_state == S_WAIT) && finalReady[c] && !r_done[c]) begin
                    r_m_data[c*32 +: 32] <= finalAccumulate[c*32 +: 32];
                end
            end

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if ((r_state == S_OUT) && m_ready) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign multiplier_output   = r_mult;
    assign multiplicand_output = r_mcand;
    assign m_data              = r_m_data;
    assign timeout_err         = r_timeout_err;

endmodule
